instr_fetch_unit: RTL and testbench

//  Front-end stage that feeds the instruction decoder. Holds the PC, reads 17-bit instructions

---
 rtl/mcu_pkg.sv | 47 ++++
 rtl/ifu_skid_buf.sv | 88 ++++++++
 rtl/instr_fetch_unit.sv | 189 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// -----------------------------------------------------------------------------
// mcu_pkg
// Shared definitions for the MCU front end: instruction width, the NOP
// encoding, the branch-select encodings driven by execute, the fetch-unit
// FSM state encoding and the redirect decision helper.
// -----------------------------------------------------------------------------
package mcu_pkg;

    localparam int              INSTR_W   = 17;
    localparam logic [16:0]     NOP_INSTR = 17'h0_0000;

    // Branch-select encodings presented with br_valid.
    typedef enum logic [1:0] {
        BS_SEQ   = 2'b00,   // sequential, no redirect
        BS_COND  = 2'b01,   // conditional, relative target
        BS_JREG  = 2'b10,   // unconditional, absolute target from register
        BS_COND2 = 2'b11    // conditional, relative target (alias)
    } br_sel_e;

    // Fetch-unit sequencing states.
    typedef enum logic [1:0] {
        ST_BOOT   = 2'b00,
        ST_RUN    = 2'b01,
        ST_DRAIN  = 2'b10,
        ST_HALTED = 2'b11
    } ifu_state_e;

    // Decide whether a branch resolution redirects the fetch stream.
    // Conditional branches are taken when the zero flag differs from the
    // polarity bit, so br_ps=0 means "branch if zero".
    function automatic logic redirect_taken(
        input logic       valid,
        input logic [1:0] sel,
        input logic       zero,
        input logic       ps
    );
        logic taken;
        case (sel)
            BS_JREG:           taken = 1'b1;
            BS_COND, BS_COND2: taken = zero ^ ps;
            BS_SEQ:            taken = 1'b0;
            default:           taken = 1'b0;
        endcase
        return valid & taken;
    endfunction

endpackage

// File: rtl/ifu_skid_buf.sv
// -----------------------------------------------------------------------------
// ifu_skid_buf
// Two-entry in-order buffer of {instruction, pc} pairs sitting between the
// instruction memory return path and the decoder handshake. Entry 0 is the
// head presented to the decoder; a pop shifts entry 1 down.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush              discard all entries (wrong-path clean-up)
//   push, push_instr,
//   push_pc            write a returned word at the tail
//   pop                remove the head (decoder accepted it)
//   head_instr,head_pc current head entry
//   count              number of valid entries (0..2)
// The caller never pushes into a full buffer nor pops an empty one.
// -----------------------------------------------------------------------------
module ifu_skid_buf
    import mcu_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic [PC_W-1:0]    push_pc,
    input  logic               pop,
    output logic [INSTR_W-1:0] head_instr,
    output logic [PC_W-1:0]    head_pc,
    output logic [1:0]         count
);

    logic [INSTR_W-1:0] instr0_r;
    logic [INSTR_W-1:0] instr1_r;
    logic [PC_W-1:0]    pc0_r;
    logic [PC_W-1:0]    pc1_r;
    logic [1:0]         count_r;

    // Buffer storage and occupancy update for push/pop/flush.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instr0_r <= NOP_INSTR;
            instr1_r <= NOP_INSTR;
            pc0_r    <= {PC_W{1'b0}};
            pc1_r    <= {PC_W{1'b0}};
            count_r  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        instr0_r <= push_instr;
                        pc0_r    <= push_pc;
                    end else begin
                        instr1_r <= push_instr;
                        pc1_r    <= push_pc;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    instr0_r <= instr1_r;
                    pc0_r    <= pc1_r;
                    count_r  <= count_r - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word lands behind
                    // whatever remains after the head leaves.
                    if (count_r == 2'd1) begin
                        instr0_r <= push_instr;
                        pc0_r    <= push_pc;
                    end else begin
                        instr0_r <= instr1_r;
                        pc0_r    <= pc1_r;
                        instr1_r <= push_instr;
                        pc1_r    <= push_pc;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign head_instr = instr0_r;
    assign head_pc    = pc0_r;
    assign count      = count_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Front-end stage feeding the decoder. Holds the PC, issues reads to a
// synchronous instruction memory (one-cycle read latency), buffers returned
// words in a 2-entry skid buffer and presents them with valid/ready.
// Downstream branch resolutions redirect the PC and flush wrong-path words.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_en, imem_addr       memory read strobe / address (current PC)
//   imem_rdata               word returned the cycle after imem_en
//   instr, instr_pc,
//   instr_valid, id_ready    decoder handshake
//   br_valid, br_sel, br_ps,
//   br_zero, br_offset,
//   br_reg_tgt               branch resolution from execute
//   halt, halted             stop request / halted status
// Optional build macro IFU_PERF_CNT_EN adds saturating counters
//   perf_fetch (accepted handshakes) and perf_flush (taken redirects).
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import mcu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               id_ready,
    input  logic               br_valid,
    input  logic [1:0]         br_sel,
    input  logic               br_ps,
    input  logic               br_zero,
    input  logic [PC_W-1:0]    br_offset,
    input  logic [PC_W-1:0]    br_reg_tgt,
    input  logic               halt,
    output logic               halted
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [15:0]        perf_fetch,
    output logic [15:0]        perf_flush
`endif
);

    ifu_state_e         state_r;
    logic [PC_W-1:0]    pc_r;
    logic               inflight_r;   // a read issued last cycle returns now

    logic [1:0]         count_s;
    logic [INSTR_W-1:0] head_instr_s;
    logic [PC_W-1:0]    head_pc_s;
    logic               valid_s;
    logic               pop_s;
    logic               push_s;
    logic               taken_s;
    logic               fetch_s;
    logic [PC_W-1:0]    target_s;
    logic [2:0]         occ_s;

    // Handshake, redirect and fetch-issue decisions for the current cycle.
    always_comb begin
        valid_s = (count_s != 2'd0);
        pop_s   = valid_s & id_ready;

        if (state_r != ST_HALTED) begin
            taken_s = redirect_taken(br_valid, br_sel, br_zero, br_ps);
        end else begin
            taken_s = 1'b0;
        end

        // For relative branches execute supplies the branch PC on br_reg_tgt.
        if (br_sel == BS_JREG) begin
            target_s = br_reg_tgt;
        end else begin
            target_s = br_reg_tgt + br_offset;
        end

        // Occupancy after this cycle's pop; counting the pop keeps the
        // stream at one word per cycle while the decoder is ready.
        occ_s = {2'b00, inflight_r} + {1'b0, count_s} - {2'b00, pop_s};

        fetch_s = !rst && (state_r == ST_RUN) && !halt && !taken_s
                  && (occ_s < 3'd2);

        // A word returning in a redirect cycle is on the wrong path.
        push_s = inflight_r & !taken_s;
    end

    // Sequencer: FSM state, PC and in-flight read tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_BOOT;
            pc_r       <= RESET_PC;
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= fetch_s;

            if (taken_s) begin
                pc_r <= target_s;
            end else if (fetch_s) begin
                pc_r <= pc_r + {{(PC_W-1){1'b0}}, 1'b1};
            end else begin
                pc_r <= pc_r;
            end

            case (state_r)
                ST_BOOT: begin
                    state_r <= ST_RUN;
                end
                ST_RUN: begin
                    // A redirect in the same cycle takes priority over halt.
                    if (halt && !taken_s) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if ((count_s == 2'd0) && !inflight_r) begin
                        state_r <= ST_HALTED;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_HALTED: begin
                    state_r <= ST_HALTED;
                end
                default: begin
                    state_r <= ST_BOOT;
                end
            endcase
        end
    end

    ifu_skid_buf #(
        .PC_W (PC_W)
    ) u_skid_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (taken_s),
        .push       (push_s),
        .push_instr (imem_rdata),
        .push_pc    (pc_r - {{(PC_W-1){1'b0}}, 1'b1}),
        .pop        (pop_s),
        .head_instr (head_instr_s),
        .head_pc    (head_pc_s),
        .count      (count_s)
    );

    assign imem_en     = fetch_s;
    assign imem_addr   = pc_r;
    assign instr_valid = valid_s;
    assign instr       = valid_s ? head_instr_s : NOP_INSTR;
    assign instr_pc    = valid_s ? head_pc_s : {PC_W{1'b0}};
    assign halted      = (state_r == ST_HALTED);

`ifdef IFU_PERF_CNT_EN
    logic [15:0] perf_fetch_r;
    logic [15:0] perf_flush_r;

    // Saturating event counters for accepted handshakes and taken redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_r <= 16'h0000;
            perf_flush_r <= 16'h0000;
        end else begin
            if (pop_s && (perf_fetch_r != 16'hFFFF)) begin
                perf_fetch_r <= perf_fetch_r + 16'h0001;
            end else begin
                perf_fetch_r <= perf_fetch_r;
            end
            if (taken_s && (perf_flush_r != 16'hFFFF)) begin
                perf_flush_r <= perf_flush_r + 16'h0001;
            end else begin
                perf_flush_r <= perf_flush_r;
            end
        end
    end

    assign perf_fetch = perf_fetch_r;
    assign perf_flush = perf_flush_r;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit. The instruction memory model returns
// word (addr + 1) one cycle after a read strobe, so every delivered
// instruction can be checked against its PC. Cycle numbers in the comments
// count rising edges after rst is released (cycle 0 = first cycle with rst=0).
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [16:0] imem_rdata = 17'h0;
    logic [16:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        id_ready;
    logic        br_valid;
    logic [1:0]  br_sel;
    logic        br_ps;
    logic        br_zero;
    logic [7:0]  br_offset;
    logic [7:0]  br_reg_tgt;
    logic        halt;
    logic        halted;
`ifdef IFU_PERF_CNT_EN
    logic [15:0] perf_fetch;
    logic [15:0] perf_flush;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Synchronous memory model: word = address + 1.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= {9'b0, imem_addr} + 17'd1;
    end

    instr_fetch_unit #(
        .PC_W     (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .id_ready    (id_ready),
        .br_valid    (br_valid),
        .br_sel      (br_sel),
        .br_ps       (br_ps),
        .br_zero     (br_zero),
        .br_offset   (br_offset),
        .br_reg_tgt  (br_reg_tgt),
        .halt        (halt),
        .halted      (halted)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch  (perf_fetch),
        .perf_flush  (perf_flush)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decoder sees a valid word for pc, whose content is pc+1.
    task automatic check_out(input string tag, input logic [7:0] pc);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_pc"},    {24'd0, instr_pc},    {24'd0, pc});
        chk({tag, "_instr"}, {15'd0, instr},       {15'd0, ({9'b0, pc} + 17'd1)});
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    endtask

    task automatic check_fetch(input string tag, input logic [7:0] addr);
        chk({tag, "_en"},   {31'd0, imem_en},   32'd1);
        chk({tag, "_addr"}, {24'd0, imem_addr}, {24'd0, addr});
    endtask

    task automatic check_nofetch(input string tag);
        chk({tag, "_en"}, {31'd0, imem_en}, 32'd0);
    endtask

    // Advance to just after the next rising edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        id_ready   = 1'b1;
        br_valid   = 1'b0;
        br_sel     = 2'b00;
        br_ps      = 1'b0;
        br_zero    = 1'b0;
        br_offset  = 8'h00;
        br_reg_tgt = 8'h00;
        halt       = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) next();
        #1;
        check_idle("rst");
        chk("rst_instr",  {15'd0, instr},    32'd0);
        chk("rst_pc",     {24'd0, instr_pc}, 32'd0);
        chk("rst_halted", {31'd0, halted},   32'd0);
        check_nofetch("rst_fetch");
`ifdef IFU_PERF_CNT_EN
        chk("rst_perf_fetch", {16'd0, perf_fetch}, 32'd0);
        chk("rst_perf_flush", {16'd0, perf_flush}, 32'd0);
`endif

        // ---------------- startup and streaming ----------------
        rst = 1'b0; #1;                                   // cycle 0: BOOT
        check_nofetch("boot");
        next(); #1; check_fetch("c1", 8'h00); check_idle("c1");
        next(); #1; check_fetch("c2", 8'h01); check_idle("c2");
        next(); #1; check_out("c3", 8'h00);
        next(); #1; check_out("c4", 8'h01);
        next(); #1; check_out("c5", 8'h02);

        // ---------------- decoder stall for 4 cycles ----------------
        next(); id_ready = 1'b0; #1;                      // cycle 6
        check_out("stall6", 8'h03); check_nofetch("stall6");
        for (int i = 0; i < 3; i++) begin                 // cycles 7..9
            next(); #1;
            check_out("stall", 8'h03); check_nofetch("stall");
        end
        next(); id_ready = 1'b1; #1;                      // cycle 10
        check_out("res10", 8'h03); check_fetch("res10", 8'h05);
        next(); #1; check_out("res11", 8'h04);
        next(); #1; check_out("res12", 8'h05);

        // ---------------- taken conditional: 0x10 + 0xFC = 0x0C ----------------
        next();                                           // cycle 13
        br_valid = 1'b1; br_sel = 2'b01; br_ps = 1'b0; br_zero = 1'b1;
        br_reg_tgt = 8'h10; br_offset = 8'hFC; #1;
        check_out("br13", 8'h06); check_nofetch("br13");
        next(); br_valid = 1'b0; #1;                      // cycle 14
        check_idle("br14"); check_fetch("br14", 8'h0C);
        next(); #1; check_idle("br15"); check_fetch("br15", 8'h0D);
        next(); #1; check_out("br16", 8'h0C);

        // ---------------- not-taken conditional and seq select ----------------
        next();                                           // cycle 17
        br_valid = 1'b1; br_sel = 2'b01; br_ps = 1'b1; br_zero = 1'b1; #1;
        check_out("nt17", 8'h0D); check_fetch("nt17", 8'h0F);
        next();                                           // cycle 18
        br_sel = 2'b00; br_ps = 1'b0; br_zero = 1'b0; #1;
        check_out("seq18", 8'h0E); check_fetch("seq18", 8'h10);

        // ---------------- jump register to 0x40 ----------------
        next();                                           // cycle 19
        br_sel = 2'b10; br_reg_tgt = 8'h40; #1;
        check_out("jr19", 8'h0F); check_nofetch("jr19");
        next(); br_valid = 1'b0; #1;                      // cycle 20
        check_idle("jr20"); check_fetch("jr20", 8'h40);
        next(); #1; check_idle("jr21"); check_fetch("jr21", 8'h41);

        // ---------------- PC wrap 0xFF -> 0x00 ----------------
        next();                                           // cycle 22
        br_valid = 1'b1; br_sel = 2'b10; br_reg_tgt = 8'hFE; #1;
        check_out("jr22", 8'h40); check_nofetch("jr22");
        next(); br_valid = 1'b0; #1;                      // cycle 23
        check_idle("wr23"); check_fetch("wr23", 8'hFE);
        next(); #1; check_fetch("wr24", 8'hFF);
        next(); #1; check_out("wr25", 8'hFE); check_fetch("wrap", 8'h00);
        next(); #1; check_out("wr26", 8'hFF);

        // ---------------- halt with two words buffered ----------------
        next(); id_ready = 1'b0; #1;                      // cycle 27
        check_out("h27", 8'h00); check_nofetch("h27");
        next(); halt = 1'b1; #1;                          // cycle 28
        check_out("h28", 8'h00); check_nofetch("h28");
        next(); id_ready = 1'b1; #1;                      // cycle 29: DRAIN
        check_out("h29", 8'h00); check_nofetch("h29");
        next(); #1; check_out("h30", 8'h01); check_nofetch("h30");
        next(); #1;                                       // cycle 31
        check_idle("h31"); chk("h31_halted", {31'd0, halted}, 32'd0);
        next(); halt = 1'b0; #1;                          // cycle 32
        chk("h32_halted", {31'd0, halted}, 32'd1);
        check_nofetch("h32"); check_idle("h32");
        next(); #1;
        chk("h33_halted", {31'd0, halted}, 32'd1); check_nofetch("h33");

        // ---------------- reset out of HALTED, counter scenario ----------------
        rst = 1'b1;
        next(); #1;
        chk("r2_halted", {31'd0, halted}, 32'd0); check_idle("r2");
`ifdef IFU_PERF_CNT_EN
        chk("r2_perf_fetch", {16'd0, perf_fetch}, 32'd0);
        chk("r2_perf_flush", {16'd0, perf_flush}, 32'd0);
`endif
        rst = 1'b0;                                       // cycle 0
        next(); next(); next(); #1;                       // cycle 3
        check_out("p3", 8'h00);
        next(); #1; check_out("p4", 8'h01);
        next(); #1; check_out("p5", 8'h02);
        next(); #1; check_out("p6", 8'h03);
        next();                                           // cycle 7
        br_valid = 1'b1; br_sel = 2'b10; br_reg_tgt = 8'h20; #1;
        check_out("p7", 8'h04);
        next();                                           // cycle 8
        br_sel = 2'b01; br_ps = 1'b0; br_zero = 1'b1;
        br_reg_tgt = 8'h30; br_offset = 8'h00; #1;
        check_idle("p8"); check_nofetch("p8");
        next(); br_valid = 1'b0; #1;                      // cycle 9
        check_fetch("p9", 8'h30);
`ifdef IFU_PERF_CNT_EN
        chk("perf_fetch", {16'd0, perf_fetch}, 32'd5);
        chk("perf_flush", {16'd0, perf_flush}, 32'd2);
`endif
        rst = 1'b1;
        next(); #1;
        check_idle("r3"); check_nofetch("r3");
`ifdef IFU_PERF_CNT_EN
        chk("r3_perf_fetch", {16'd0, perf_fetch}, 32'd0);
        chk("r3_perf_flush", {16'd0, perf_flush}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
